// File: rtl/register_file.sv
// RV32I integer register file with write-through bypass and a pending-write
// scoreboard feeding the hazard unit. Two identical read ports share the array.

module register_file_rd_port #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int ADDR_W    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic                        byp_ok,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            pending,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [XLEN-1:0]             rd_data,
  output logic                        rd_pending
);
  logic wr_hit;

  assign wr_hit = wr_en && (wr_addr == rd_addr) && (rd_addr != '0);

  always_comb begin
    rd_data = '0;
    if (rd_addr != '0) begin
      if ((BYPASS_EN != 0) && byp_ok && wr_hit) rd_data = wr_data;
      else                                       rd_data = regs[rd_addr];
    end
  end

  // A retiring write is already forwarded, so it no longer counts as a hazard.
  assign rd_pending = (rd_addr != '0) && pending[rd_addr] && !wr_hit;
endmodule

module register_file #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int ADDR_W    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic              sb_flush,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              any_pending
);
  localparam int NUM_RD = 2;

  logic [NREGS-1:0][XLEN-1:0]  regs;
  logic [NREGS-1:0]            pending, pending_nxt;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]   rd_data;
  logic [NUM_RD-1:0]             rd_pending;

  always_ff @(posedge clk) begin
    if (!rst_n)                          regs <= '0;
    else if (wr_en && wr_addr != '0)     regs[wr_addr] <= wr_data;
  end

  // Priority: flush, then retire, then issue; issue wins so a surviving
  // newer writer stays outstanding.
  always_comb begin
    pending_nxt = pending;
    if (sb_flush)   pending_nxt = '0;
    else if (wr_en) pending_nxt[wr_addr] = 1'b0;
    if (sb_set_en && sb_set_addr != '0) pending_nxt[sb_set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign rd_addr = {rs2_addr, rs1_addr};

  // Bypass is masked while reset is held so the ports read as cleared state.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    register_file_rd_port #(
      .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)
    ) u_port (
      .byp_ok    (rst_n),
      .regs      (regs),
      .pending   (pending),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr[p]),
      .rd_data   (rd_data[p]),
      .rd_pending(rd_pending[p])
    );
  end

  assign rs1_data    = rd_data[0];
  assign rs2_data    = rd_data[1];
  assign rs1_pending = rd_pending[0];
  assign rs2_pending = rd_pending[1];
  assign any_pending = |pending;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one bypassing instance and one without bypass.

module tb_register_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic        sb_set_en, sb_flush;
  logic [4:0]  sb_set_addr;
  logic        rs1_pending, rs2_pending, any_pending;
  logic        nb_rs1_pending, nb_rs2_pending, nb_any_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file #(.BYPASS_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending), .any_pending(any_pending)
  );

  register_file #(.BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .rs1_pending(nb_rs1_pending), .rs2_pending(nb_rs2_pending), .any_pending(nb_any_pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; sb_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); rs1_addr = '0; rs2_addr = '0;
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5;  wr_data = 32'h1111_1111; tick();
    wr_addr = 5'd31; wr_data = 32'h2222_2222; tick();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd6; tick();
    // In-flight write and set on the reset edge must be discarded.
    rst_n = 1'b0; idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
    sb_set_en = 1'b1; sb_set_addr = 5'd5;
    tick();
    idle(); rs1_addr = 5'd5; rs2_addr = 5'd31; #1;
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL rst_hold_rs1 got %h exp 0", rs1_data); end
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL rst_hold_rs2 got %h exp 0", rs2_data); end
    tick();
    rst_n = 1'b1; #1;
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL rst_rs1 got %h exp 0", rs1_data); end
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL rst_rs2 got %h exp 0", rs2_data); end
    checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL rst_any got %b exp 0", any_pending); end
    checks++; if (nb_any_pending !== 1'b0) begin errors++; $display("FAIL rst_nb_any got %b exp 0", nb_any_pending); end
    rs1_addr = 5'd6; #1;
    checks++; if (rs1_pending !== 1'b0) begin errors++; $display("FAIL rst_pend6 got %b exp 0", rs1_pending); end
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF; tick();
    idle(); rs1_addr = 5'd7; #1;
    checks++; if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_x7 got %h exp deadbeef", rs1_data); end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; tick();
    idle(); rs2_addr = 5'd0; #1;
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL wr_x0 got %h exp 0", rs2_data); end
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hCAFE_F00D; tick();
    idle(); rs2_addr = 5'd31; #1;
    checks++; if (rs2_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_x31 got %h exp cafef00d", rs2_data); end
    checks++; if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL keep_x7 got %h exp deadbeef", rs1_data); end
  endtask

  task automatic test_bypass();
    idle(); rs1_addr = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5; #1;
    checks++; if (rs1_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_on got %h exp a5a5a5a5", rs1_data); end
    checks++; if (nb_rs1_data !== 32'h0) begin errors++; $display("FAIL byp_off got %h exp 0", nb_rs1_data); end
    tick();
    idle(); #1;
    checks++; if (nb_rs1_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_off_after got %h exp a5a5a5a5", nb_rs1_data); end
    rs1_addr = 5'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; #1;
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL byp_x0 got %h exp 0", rs1_data); end
    tick(); idle();
  endtask

  task automatic test_scoreboard();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd10; tick();
    idle(); rs1_addr = 5'd10; #1;
    checks++; if (rs1_pending !== 1'b1) begin errors++; $display("FAIL sb_set got %b exp 1", rs1_pending); end
    checks++; if (any_pending !== 1'b1) begin errors++; $display("FAIL sb_any got %b exp 1", any_pending); end
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0BAD_CAFE; #1;
    checks++; if (rs1_pending !== 1'b0) begin errors++; $display("FAIL sb_retire_pend got %b exp 0", rs1_pending); end
    checks++; if (rs1_data !== 32'h0BAD_CAFE) begin errors++; $display("FAIL sb_retire_data got %h exp 0badcafe", rs1_data); end
    tick();
    idle(); #1;
    checks++; if (rs1_pending !== 1'b0) begin errors++; $display("FAIL sb_after_pend got %b exp 0", rs1_pending); end
    checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL sb_after_any got %b exp 0", any_pending); end
    sb_set_en = 1'b1; sb_set_addr = 5'd0; tick();
    idle(); rs1_addr = 5'd0; #1;
    checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL sb_x0_any got %b exp 0", any_pending); end
  endtask

  task automatic test_collision();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd4; tick();
    idle(); rs2_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4444_4444;
    sb_set_en = 1'b1; sb_set_addr = 5'd4; tick();
    idle(); #1;
    checks++; if (rs2_pending !== 1'b1) begin errors++; $display("FAIL coll_pend got %b exp 1", rs2_pending); end
    checks++; if (rs2_data !== 32'h4444_4444) begin errors++; $display("FAIL coll_data got %h exp 44444444", rs2_data); end
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h5555_5555; tick();
    idle(); #1;
    checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL coll_drain got %b exp 0", any_pending); end
  endtask

  task automatic test_flush();
    idle();
    sb_set_en = 1'b1;
    sb_set_addr = 5'd1; tick();
    sb_set_addr = 5'd2; tick();
    sb_set_addr = 5'd3; tick();
    sb_flush = 1'b1; sb_set_addr = 5'd9; tick();
    idle(); rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    checks++; if (rs1_pending !== 1'b0) begin errors++; $display("FAIL fl_x1 got %b exp 0", rs1_pending); end
    checks++; if (rs2_pending !== 1'b0) begin errors++; $display("FAIL fl_x2 got %b exp 0", rs2_pending); end
    rs1_addr = 5'd3; rs2_addr = 5'd9; #1;
    checks++; if (rs1_pending !== 1'b0) begin errors++; $display("FAIL fl_x3 got %b exp 0", rs1_pending); end
    checks++; if (rs2_pending !== 1'b1) begin errors++; $display("FAIL fl_x9 got %b exp 1", rs2_pending); end
    checks++; if (any_pending !== 1'b1) begin errors++; $display("FAIL fl_any got %b exp 1", any_pending); end
    // Write to a flushed, non-pending register still lands in the array.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3333_0003; tick();
    idle(); sb_flush = 1'b1; tick();
    idle(); #1;
    checks++; if (rs1_data !== 32'h3333_0003) begin errors++; $display("FAIL fl_wr_x3 got %h exp 33330003", rs1_data); end
    checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL fl_clear got %b exp 0", any_pending); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file and pending-write scoreboard for the 5-stage RV32I pipeline.
- Consumes `wr_data`/`wr_en`/`wr_addr` from the writeback stage and serves the two decode-stage source operands.
- Write-through bypass: a value written in cycle N is visible to a same-cycle decode read.
- The scoreboard tracks destinations issued but not yet written back, so the hazard unit can stall.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; index 0 is hardwired to zero.
- ADDR_W, 5, register index width (clog2 of NREGS).
- BYPASS_EN, 1, 1 enables write-to-read bypass in the same cycle; 0 returns the stored value only.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- wr_en  input  1  writeback write enable (RegWrite from MEM/WB)
- wr_addr  input  ADDR_W  writeback destination index
- wr_data  input  XLEN  writeback data (ALU result, load data or PC+4, already selected)
- rs1_addr  input  ADDR_W  decode source 1 index
- rs2_addr  input  ADDR_W  decode source 2 index
- rs1_data  output  XLEN  source 1 operand, combinational
- rs2_data  output  XLEN  source 2 operand, combinational
- sb_set_en  input  1  decode issues an instruction that will write sb_set_addr
- sb_set_addr  input  ADDR_W  destination index being issued
- sb_flush  input  1  branch/jump flush; clears all pending bits
- rs1_pending  output  1  rs1_addr has an outstanding write not yet retired
- rs2_pending  output  1  rs2_addr has an outstanding write not yet retired
- any_pending  output  1  OR of all pending bits (drain indicator)

Behaviour:
- Storage: NREGS x XLEN array plus an NREGS-bit pending vector. Entry 0 is never written and always reads 0; its pending bit is never set.
- Reset: when rst_n=0 at a rising edge, all registers clear to 0 and all pending bits clear to 0 in that single cycle. Writes and sets in that cycle are ignored.
  - With all state cleared, every output reads 0 (rsX_data=0, rsX_pending=0, any_pending=0) while reset is held, for any address.
- Write: on a rising edge with rst_n=1, wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. A write to index 0 is silently dropped.
- Read: rsX_data = 0 if rsX_addr=0.
  - Otherwise, if BYPASS_EN=1 and wr_en=1 and wr_addr=rsX_addr, the result is wr_data.
  - Otherwise the result is reg[rsX_addr].
  - Read latency is zero cycles (combinational); write latency is one edge.
- Scoreboard per edge, evaluated in priority order:
  1. sb_flush=1: all pending bits clear, except that a simultaneous sb_set_en still sets its bit. The set comes from a surviving instruction in decode.
  2. Retire: wr_en=1 clears pending[wr_addr].
  3. Issue: sb_set_en=1 and sb_set_addr!=0 sets pending[sb_set_addr]. Set wins over a same-cycle retire to the same index, because the newer writer is outstanding.
- Pending outputs: rsX_pending = pending[rsX_addr] AND NOT (wr_en AND wr_addr=rsX_addr). The retiring write is bypassed, so it does not count as pending. rsX_pending is always 0 for index 0.
- A write with no pending bit set (e.g. after a flush) still updates the array; the scoreboard bit stays clear.
- Reset asserted mid-stream discards any in-flight set/write of that edge. The first post-reset edge behaves as from idle.
- No X propagation: addresses are full-range, so no out-of-range case exists when NREGS=2^ADDR_W.

Test Plan:
- Reset then read: hold rst_n=0 for 2 cycles after random writes to x5/x31, release; read rs1=5, rs2=31 -> rs1_data=0, rs2_data=0, any_pending=0.
- Write then read: write x7=0xDEADBEEF; next cycle rs1_addr=7 -> 0xDEADBEEF. Write x0=0x12345678, read rs2_addr=0 -> 0x00000000.
- Same-cycle bypass: wr_en=1, wr_addr=3, wr_data=0xA5A5A5A5 with rs1_addr=3 in the same cycle -> rs1_data=0xA5A5A5A5 combinationally. With BYPASS_EN=0 -> old value 0.
- Scoreboard lifecycle: sb_set x10 -> next cycle rs1_addr=10 gives rs1_pending=1.
  - In the cycle wr_en=1, wr_addr=10: rs1_pending=0 and rs1_data=wr_data.
  - After that edge, pending stays 0 and any_pending=0.
- Set/retire collision: pending[4]=1; same edge wr_en=1, wr_addr=4 and sb_set_en=1, sb_set_addr=4 -> pending[4] stays 1 and rs2_pending=1 next cycle. Array holds the written value.
- Flush with concurrent issue: pending x1, x2, x3 set; edge with sb_flush=1, sb_set_en=1, sb_set_addr=9 -> only pending[9]=1; x1..x3 read not pending; any_pending=1.
